// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: latches operands at start, holds the result
// pending for a fixed number of busy cycles, then writes HI/LO.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    // Declaration initialisers give the reset values at time zero in simulation
    logic [0:0]       r_state   = ST_IDLE;
    logic [CNT_W-1:0] r_cnt     = '0;
    logic [31:0]      r_hi      = '0;
    logic [31:0]      r_lo      = '0;
    logic [31:0]      r_pend_hi = '0;
    logic [31:0]      r_pend_lo = '0;
    logic             r_pend_wr = 1'b0;

    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      w_hi_nxt;
    logic [31:0]      w_lo_nxt;
    logic [31:0]      w_pend_hi_nxt;
    logic [31:0]      w_pend_lo_nxt;
    logic             w_pend_wr_nxt;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_div_b;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;

    // Operand datapath; a zero divisor is replaced by 1 only to keep the
    // dividers defined, the result is never written in that case.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};
    assign w_div_b  = (b == 32'd0) ? 32'd1 : b;
    assign w_quo_u  = a / w_div_b;
    assign w_rem_u  = a % w_div_b;
    // Signed divide via magnitudes: 0x80000000 / -1 naturally yields 0x80000000 r 0
    assign w_a_mag  = a[31] ? (32'd0 - a) : a;
    assign w_b_mag  = w_div_b[31] ? (32'd0 - w_div_b) : w_div_b;
    assign w_mag_q  = w_a_mag / w_b_mag;
    assign w_mag_r  = w_a_mag % w_b_mag;
    assign w_quo_s  = (a[31] ^ w_div_b[31]) ? (32'd0 - w_mag_q) : w_mag_q;
    assign w_rem_s  = a[31] ? (32'd0 - w_mag_r) : w_mag_r;

    // Next-state and next-value logic for the IDLE/BUSY sequencer
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_wr_nxt = r_pend_wr;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            w_pend_hi_nxt = (op == OP_MULT) ? w_prod_s[63:32] : w_prod_u[63:32];
                            w_pend_lo_nxt = (op == OP_MULT) ? w_prod_s[31:0]  : w_prod_u[31:0];
                            w_pend_wr_nxt = 1'b1;
                            w_cnt_nxt     = CNT_W'(MULT_CYCLES);
                            w_state_nxt   = ST_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_pend_hi_nxt = (op == OP_DIV) ? w_rem_s : w_rem_u;
                            w_pend_lo_nxt = (op == OP_DIV) ? w_quo_s : w_quo_u;
                            w_pend_wr_nxt = (b != 32'd0);
                            w_cnt_nxt     = CNT_W'(DIV_CYCLES);
                            w_state_nxt   = ST_BUSY;
                        end
                        OP_MTHI: w_hi_nxt = a;
                        OP_MTLO: w_lo_nxt = a;
                        default: ;
                    endcase
                end
            end
            default: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    if (r_pend_wr) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end
            end
        endcase
    end

    // State and data registers with synchronous reset priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_wr <= w_pend_wr_nxt;
        end
    end

    assign busy = (r_state == ST_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: busy length, HI/LO results, MTHI/MTLO,
// ignored starts, divide by zero and mid-operation reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one start edge, scramble operands, then expect n busy cycles
    // with HI/LO held at their old values, followed by the new result.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = hi;
        old_lo = lo;
        start = 1'b1; op = o; a = va; b = vb;
        tick();
        start = 1'b0; op = 4'd0; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_hold_hi"}, hi, old_hi);
            chk({tag, "_hold_lo"}, lo, old_lo);
            tick();
        end
        chk({tag, "_done"}, 32'(busy), 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;

        // Time-zero values before any edge
        #1;
        chk("t0_hi", hi, 32'd0);
        chk("t0_lo", lo, 32'd0);
        chk("t0_busy", 32'(busy), 32'd0);

        // Reset has priority over start
        start = 1'b1; op = 4'd6; a = 32'h5555_5555;
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        start = 1'b0; op = 4'd0; reset = 1'b0;
        tick();

        run_op("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_nn", 4'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 5, 32'h0000_0000, 32'h0000_0006);
        run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

        // MTHI then MTLO in IDLE: single-edge writes, busy stays low
        start = 1'b1; op = 4'd5; a = 32'h11;
        tick();
        start = 1'b0; op = 4'd0;
        chk("mthi_hi", hi, 32'h11);
        chk("mthi_lo", lo, 32'h8000_0000);
        chk("mthi_busy", 32'(busy), 32'd0);
        start = 1'b1; op = 4'd6; a = 32'h22;
        tick();
        start = 1'b0; op = 4'd0;
        chk("mtlo_hi", hi, 32'h11);
        chk("mtlo_lo", lo, 32'h22);
        chk("mtlo_busy", 32'(busy), 32'd0);

        run_op("divu_z", 4'd4, 32'd1234, 32'd0, 10, 32'h11, 32'h22);

        // MULTU with an MTHI attempt on busy cycle 2
        start = 1'b1; op = 4'd2; a = 32'hFFFF_FFFF; b = 32'd2;
        tick();
        start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
        chk("mu_c1_busy", 32'(busy), 32'd1);
        tick();
        chk("mu_c2_busy", 32'(busy), 32'd1);
        start = 1'b1; op = 4'd5; a = 32'h1234;
        tick();
        start = 1'b0; op = 4'd0;
        for (int i = 3; i <= 5; i++) begin
            chk("mu_busy", 32'(busy), 32'd1);
            chk("mu_hold_hi", hi, 32'h11);
            tick();
        end
        chk("mu_done", 32'(busy), 32'd0);
        chk("mu_hi", hi, 32'h0000_0001);
        chk("mu_lo", lo, 32'hFFFF_FFFE);

        // MTLO in IDLE leaves HI alone
        start = 1'b1; op = 4'd6; a = 32'hABCD;
        tick();
        start = 1'b0; op = 4'd0;
        chk("mtlo2_lo", lo, 32'hABCD);
        chk("mtlo2_hi", hi, 32'h0000_0001);
        chk("mtlo2_busy", 32'(busy), 32'd0);
        tick();
        chk("mtlo2_busy2", 32'(busy), 32'd0);

        // Undefined op codes do nothing
        start = 1'b1; op = 4'd7; a = 32'h9999;
        tick();
        op = 4'd0;
        tick();
        op = 4'd15;
        tick();
        start = 1'b0; op = 4'd0;
        chk("nop_hi", hi, 32'h0000_0001);
        chk("nop_lo", lo, 32'hABCD);
        chk("nop_busy", 32'(busy), 32'd0);

        // DIV abandoned by reset on busy cycle 3
        start = 1'b1; op = 4'd3; a = 32'd50; b = 32'd5;
        tick();
        start = 1'b0; op = 4'd0;
        tick();
        tick();
        chk("rdiv_c3_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rdiv_busy", 32'(busy), 32'd0);
        chk("rdiv_hi", hi, 32'd0);
        chk("rdiv_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rdiv_late_lo", lo, 32'd0);
            chk("rdiv_late_busy", 32'(busy), 32'd0);
        end

        run_op("multu_post", 4'd2, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving busy cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving busy cycles for DIV/DIVU.
REQ-003 The block SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, asserted while a HI/LO-class instruction occupies EX.
REQ-006 The block SHALL have port op, input, 4, encoded as 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; all other codes are no-op.
REQ-007 The block SHALL have port a, input, 32, the forwarded rs value from the ID/EX RD1 path.
REQ-008 The block SHALL have port b, input, 32, the forwarded rt value from the ID/EX RD2 path.
REQ-009 The block SHALL have port busy, output, 1, registered, high while an operation is in flight.
REQ-010 The block SHALL have port hi, output, 32, registered HI.
REQ-011 The block SHALL have port lo, output, 32, registered LO.

Function
REQ-012 The block SHALL have two states: IDLE (counter = 0) and BUSY (counter != 0); busy SHALL equal (state == BUSY).
REQ-013 In IDLE, at an edge with start=1 and op in 1..4, the block SHALL latch a/b, compute the result, load counter with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4), and enter BUSY.
REQ-014 In BUSY, counter SHALL decrement by 1 each edge; at the edge where it goes 1->0, hi/lo SHALL take the pending result and state SHALL return to IDLE.
REQ-015 busy SHALL be high for exactly N consecutive cycles starting the cycle after the start edge, where N is the op's cycle count; the new hi/lo SHALL be visible in the first cycle busy is low.
REQ-016 In IDLE, at an edge with start=1 and op=5 (op=6), hi (lo) SHALL take a; busy SHALL stay 0; the other register SHALL be unchanged.
REQ-017 When start=1 with busy=1, the block SHALL ignore start, leave the in-flight operation unaffected, and leave hi/lo unchanged until completion.
REQ-018 When start=1 with an op code outside 1..6, the block SHALL take no action.
REQ-019 MULT SHALL form the signed 64-bit product and MULTU the unsigned 64-bit product, with hi = bits 63:32 and lo = bits 31:0.
REQ-020 DIV SHALL give lo = signed quotient truncated toward zero and hi = remainder with the dividend's sign; DIVU SHALL give the unsigned quotient and remainder.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0x00000000.
REQ-022 Divide by zero (b=0, op 3/4) SHALL still run DIV_CYCLES busy cycles but SHALL leave hi and lo unchanged at completion.
REQ-023 a and b SHALL be sampled only at the start edge; later changes SHALL NOT affect the result.
REQ-024 The hazard unit SHALL stall ID whenever (start | busy) and the ID instruction is HI/LO-class; the block itself SHALL generate no stall.

Reset
REQ-025 While reset=1 at an edge, hi, lo and counter SHALL be 0, busy SHALL be 0, and state SHALL be IDLE, taking priority over start.
REQ-026 Reset asserted mid-operation SHALL abandon the operation, with busy=0 the following cycle and the pending result discarded.
REQ-027 The registers SHALL also initialise to the reset values at time zero, for simulation.

Verification
REQ-028 MULT, a=0xFFFFFFFD (-3), b=5 -> busy high 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFF1.
REQ-029 DIVU, a=100, b=7 -> busy high 10 cycles, then lo=14 and hi=2; DIV, a=-7, b=2 -> lo=0xFFFFFFFD and hi=0xFFFFFFFF.
REQ-030 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 and hi=0; DIVU with b=0 and prior hi=0x11, lo=0x22 -> 10 busy cycles, then hi=0x11 and lo=0x22.
REQ-031 MULTU 0xFFFFFFFF*2 started, then MTHI a=0x1234 applied on busy cycle 2 -> MTHI ignored; final hi=0x00000001 and lo=0xFFFFFFFE.
REQ-032 MTLO a=0xABCD in IDLE -> lo=0xABCD the next cycle, busy never asserts, hi unchanged.
REQ-033 DIV started, then reset asserted on busy cycle 3 -> next cycle busy=0, hi=0 and lo=0, and no late writeback occurs after reset deasserts.
